// File: rtl/ava_bram_port_arbiter_if.sv
// rtl/ava_bram_port_arbiter_if.sv - request/response and BRAM port-1 bundle for the port arbiter
interface ava_bram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int WORD_WIDTH = 32,
   parameter int GRAN_CNT   = 4
);
   logic [1:0]                 req_valid;
   logic [1:0]                 req_ready;
   logic [1:0][ADDR_WIDTH-1:0] req_addr;
   logic [1:0][GRAN_CNT-1:0]   req_we;
   logic [1:0][WORD_WIDTH-1:0] req_wdata;
   logic [1:0]                 rsp_valid;
   logic [WORD_WIDTH-1:0]      rsp_rdata;
   logic [ADDR_WIDTH-1:0]      mem_a1;
   logic [WORD_WIDTH-1:0]      mem_di1;
   logic                       mem_en1;
   logic [GRAN_CNT-1:0]        mem_we1;
   logic [WORD_WIDTH-1:0]      mem_do1;

   // master: requesters plus the BRAM itself; slave: the arbiter
   modport master (
      output req_valid, req_addr, req_we, req_wdata, mem_do1,
      input  req_ready, rsp_valid, rsp_rdata, mem_a1, mem_di1, mem_en1, mem_we1
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, mem_do1,
      output req_ready, rsp_valid, rsp_rdata, mem_a1, mem_di1, mem_en1, mem_we1
   );
endinterface

// File: rtl/ava_bram_port_arbiter.sv
// rtl/ava_bram_port_arbiter.sv - two-requester arbiter/sequencer for BRAM read/write port 1
module ava_bram_port_arbiter #(
   parameter int WORD_COUNT  = 1024,
   parameter int WORD_WIDTH  = 32,
   parameter int GRANULARITY = 8,
   parameter int MAX_WAIT    = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   ava_bram_port_arbiter_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(WORD_COUNT);
   localparam int GRAN_CNT   = WORD_WIDTH / GRANULARITY;
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [1:0] grant;
   logic [1:0] ready;
   logic       sel;
   logic       xfer;
   logic       is_wr;
   logic       rd_xfer;

   logic       rd_pend_q, rd_pend_d;
   logic       rsp_tag_q, rsp_tag_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;

   // Requester 0 wins ties until requester 1 has been denied MAX_WAIT times in a row
   always_comb begin
      grant = 2'b00;
      if (bus.req_valid[1] && (!bus.req_valid[0] || wait_cnt_q == MAX_WAIT_C)) begin
         grant = 2'b10;
      end else if (bus.req_valid[0]) begin
         grant = 2'b01;
      end
   end

   assign ready   = grant & {2{rst_n}};
   assign sel     = grant[1];
   assign xfer    = |ready;
   assign is_wr   = |bus.req_we[sel];
   assign rd_xfer = xfer && !is_wr;

   assign bus.req_ready = ready;
   assign bus.mem_a1    = bus.req_addr[sel];
   assign bus.mem_di1   = bus.req_wdata[sel];
   assign bus.mem_en1   = rd_xfer;
   assign bus.mem_we1   = xfer ? bus.req_we[sel] : {GRAN_CNT{1'b0}};

   // do1 is held while en1 is low, so a following write cannot corrupt the response
   assign bus.rsp_valid = {rd_pend_q && rsp_tag_q, rd_pend_q && !rsp_tag_q} & {2{rst_n}};
   assign bus.rsp_rdata = bus.mem_do1;

   always_comb begin
      rd_pend_d  = rd_xfer;
      rsp_tag_d  = rd_xfer ? sel : rsp_tag_q;
      wait_cnt_d = wait_cnt_q;
      if (!bus.req_valid[1] || grant[1]) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < MAX_WAIT_C) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pend_q  <= 1'b0;
         rsp_tag_q  <= 1'b0;
         wait_cnt_q <= 4'd0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rsp_tag_q  <= rsp_tag_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   logic unused_addr_width;
   assign unused_addr_width = ^ADDR_WIDTH;
endmodule

// File: doc/ava_bram_port_arbiter.md
# ava_bram_port_arbiter

Arbiter and sequencer for the read/write port (port 1) of the simple dual-port block RAM. It shares that port between two requesters: requester 0, the CPU load/store unit, and requester 1, the debug/loader master. It converts each requester's valid/ready request into BRAM enable and byte-write strobes, and routes the one-cycle-latency read data back to the owner as a tagged response. The read-only port 2 (instruction fetch) bypasses this block.

## Interface
Parameters:
- WORD_COUNT, 1024, BRAM depth in words; ADDR_WIDTH = $clog2(WORD_COUNT)
- WORD_WIDTH, 32, data width
- GRANULARITY, 8, write-strobe granularity; GRAN_CNT = WORD_WIDTH / GRANULARITY
- MAX_WAIT, 4, consecutive cycles requester 1 may be denied before it is forced a grant (range 1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- req_valid  in  [2]  request valid, per requester
- req_ready  out  [2]  request accepted this cycle
- req_addr  in  [2][ADDR_WIDTH]  word address
- req_we  in  [2][GRAN_CNT]  byte-write strobes; all-zero means read
- req_wdata  in  [2][WORD_WIDTH]  write data
- rsp_valid  out  [2]  read data valid for requester i
- rsp_rdata  out  WORD_WIDTH  read data, shared by both requesters and qualified by rsp_valid
- mem_a1  out  ADDR_WIDTH  to BRAM a1
- mem_di1  out  WORD_WIDTH  to BRAM di1
- mem_en1  out  1  to BRAM en1
- mem_we1  out  GRAN_CNT  to BRAM we1
- mem_do1  in  WORD_WIDTH  from BRAM do1

## Operation
- Grant, combinational, one per cycle:
  - Only one req_valid is set: that requester is granted.
  - Both are set: requester 0 is granted, unless wait_cnt == MAX_WAIT, in which case requester 1 is granted.
- req_ready[i] = grant[i] && rst_n. A transfer occurs when req_valid[i] && req_ready[i].
- Requests are not required to hold stable while waiting. The arbiter samples only in the transfer cycle.
- Transfer, write (any req_we bit set):
  - mem_we1 = req_we[g], mem_a1 = req_addr[g], mem_di1 = req_wdata[g], mem_en1 = 0.
  - No response is generated.
- Transfer, read (req_we all zero):
  - mem_en1 = 1, mem_we1 = 0, mem_a1 = req_addr[g].
  - rsp_tag <= g and rd_pend <= 1 are registered.
- No transfer: mem_en1 = 0 and mem_we1 = 0. mem_a1 and mem_di1 are don't-care; they are driven from requester 0.
- Response:
  - rsp_valid[i] = rd_pend && rsp_tag == i.
  - rsp_rdata = mem_do1.
  - Requesters must accept the response in that cycle; there is no backpressure.
- wait_cnt, 4-bit register:
  - Increments, saturating at MAX_WAIT, on cycles where req_valid[1] && !grant[1].
  - Clears on any grant to requester 1.
  - Clears when req_valid[1] is low.
- Reset (rst_n low at a clock edge):
  - rd_pend = 0, rsp_tag = 0, wait_cnt = 0.
  - req_ready, mem_en1, mem_we1 and rsp_valid are forced to 0 while rst_n is low.
  - A read issued in the cycle before reset asserts produces no response.

## Timing
- Request to BRAM: 0 cycles, combinational pass-through in the transfer cycle.
- Read: address accepted at edge N; rsp_valid is high for exactly one cycle, N to N+1, with the data.
- Throughput: one transfer per cycle. Back-to-back reads from the same or different requesters produce back-to-back responses, each tagged correctly.
- Write followed by a read of the same address in the next cycle returns the new data. BRAM write completes at the edge, and the read samples the updated memory one edge later.
- A write in the cycle immediately after a read does not disturb that read's response, because do1 holds while en1 = 0.
- Worst-case latency to grant for requester 1 under continuous requester-0 traffic: MAX_WAIT + 1 cycles from first req_valid[1].

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with both req_valid = 1 → req_ready = 00, mem_en1 = 0, mem_we1 = 0, rsp_valid = 00.
- Single read: requester 0 writes 0xDEADBEEF, we = 1111, to addr 5, then reads addr 5 → rsp_valid = 01 exactly one cycle after the read accept, rsp_rdata = 0xDEADBEEF.
- Byte strobes: over 0xDEADBEEF, requester 1 writes 0x000000AA with we = 0001, then reads addr 5 → rsp_valid = 10, rsp_rdata = 0xDEADBEAA.
- Starvation: with MAX_WAIT = 4, both requesters assert reads continuously (r0 addr 1, r1 addr 2) → grant pattern 0,0,0,0,1 repeating; each response carries the correct tag and data.
- Back-to-back mixed traffic: alternating r0 read, r1 read, r0 write every cycle → responses arrive in issue order, one per read, with no response for the write and no dropped or duplicated rsp_valid.
- Reset mid-operation: r1 read accepted, rst_n low on the next edge → no rsp_valid seen, and wait_cnt is 0 after reset (r0 regains priority immediately).
